// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared next-PC select codes and PC generator state encodings
package pc_gen_pkg;

    localparam int PC_SEL_WIDTH = 2;

    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_ADD4 = 2'd0;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL  = 2'd1;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR = 2'd2;
    localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_NONE = 2'd3;

    typedef enum logic [2:0] {
        PC_GEN_ST_BOOT  = 3'd0,
        PC_GEN_ST_FETCH = 3'd1,
        PC_GEN_ST_EXEC  = 3'd2,
        PC_GEN_ST_TRAP  = 3'd3,
        PC_GEN_ST_HALT  = 3'd4
    } pc_gen_state_e;

endpackage

// File: rtl/pc_gen_target.sv
// rtl/pc_gen_target.sv - combinational next-PC target select with alignment check
module pc_gen_target
    import pc_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         imm,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic                    taken,
    output logic [XLEN-1:0]         target,
    output logic                    misaligned,
    output logic                    is_halt
);

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] jalr_raw;
    logic [XLEN-1:0] jalr_mask;

    assign pc_rel    = pc + imm;
    assign jalr_raw  = rs1 + imm;
    assign jalr_mask = {{(XLEN-1){1'b1}}, 1'b0};

    // A taken branch outranks whatever the decoder selected, NONE included.
    always_comb begin
        target  = pc + XLEN'(4);
        is_halt = 1'b0;
        if (taken) begin
            target = pc_rel;
        end else begin
            case (pc_sel)
                PC_SEL_JAL:  target = pc_rel;
                PC_SEL_JALR: target = jalr_raw & jalr_mask;
                PC_SEL_NONE: is_halt = 1'b1;
                default:     target = pc + XLEN'(4);
            endcase
        end
    end

    assign misaligned = (IALIGN == 16) ? target[0] : (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - PC register, fetch handshake and commit-driven FSM; PC_GEN_PERF_EN adds perf counters
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              IALIGN       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    fetch_valid,
    input  logic                    fetch_ready,
    output logic [XLEN-1:0]         fetch_pc,
    input  logic                    commit,
    input  logic [PC_SEL_WIDTH-1:0] pc_sel,
    input  logic                    taken,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         imm,
    input  logic                    stall,
    output logic [XLEN-1:0]         pc,
    output logic                    halted,
    output logic                    trap,
    output logic [XLEN-1:0]         trap_tval
`ifdef PC_GEN_PERF_EN
    ,
    output logic [31:0]             perf_redirects,
    output logic [31:0]             perf_stall_cycles
`endif
);

    pc_gen_state_e   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tval_q, tval_d;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            is_halt;
    logic            commit_go;

    pc_gen_target #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target (
        .pc         (pc_q),
        .rs1        (rs1),
        .imm        (imm),
        .pc_sel     (pc_sel),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned),
        .is_halt    (is_halt)
    );

    assign commit_go = (state_q == PC_GEN_ST_EXEC) && commit && !stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        case (state_q)
            PC_GEN_ST_BOOT:  state_d = PC_GEN_ST_FETCH;
            PC_GEN_ST_FETCH: if (fetch_ready) state_d = PC_GEN_ST_EXEC;
            PC_GEN_ST_EXEC: begin
                if (commit_go) begin
                    if (is_halt) begin
                        state_d = PC_GEN_ST_HALT;
                    end else if (misaligned) begin
                        state_d = PC_GEN_ST_TRAP;
                        tval_d  = target;
                    end else begin
                        state_d = PC_GEN_ST_FETCH;
                        pc_d    = target;
                    end
                end
            end
            PC_GEN_ST_TRAP: begin
                state_d = PC_GEN_ST_FETCH;
                pc_d    = TRAP_VECTOR;
            end
            PC_GEN_ST_HALT:  state_d = PC_GEN_ST_HALT;
            default:         state_d = PC_GEN_ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PC_GEN_ST_BOOT;
            pc_q    <= RESET_VECTOR;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
        end
    end

    assign fetch_valid = (state_q == PC_GEN_ST_FETCH);
    assign fetch_pc    = pc_q;
    assign pc          = pc_q;
    assign halted      = (state_q == PC_GEN_ST_HALT);
    assign trap        = (state_q == PC_GEN_ST_TRAP);
    assign trap_tval   = tval_q;

`ifdef PC_GEN_PERF_EN
    logic [31:0] redirects_q, redirects_d;
    logic [31:0] stalls_q, stalls_d;
    logic        redirect_ev;
    logic        stall_ev;

    assign redirect_ev = commit_go && !is_halt && !misaligned && (target != pc_q + XLEN'(4));
    assign stall_ev    = (state_q == PC_GEN_ST_EXEC) && commit && stall;

    always_comb begin
        redirects_d = redirects_q;
        stalls_d    = stalls_q;
        if (redirect_ev && (redirects_q != 32'hFFFF_FFFF)) redirects_d = redirects_q + 32'd1;
        if (stall_ev && (stalls_q != 32'hFFFF_FFFF))       stalls_d    = stalls_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirects_q <= '0;
            stalls_q    <= '0;
        end else begin
            redirects_q <= redirects_d;
            stalls_q    <= stalls_d;
        end
    end

    assign perf_redirects    = redirects_q;
    assign perf_stall_cycles = stalls_q;
`endif

endmodule
